// File: rtl/knn_pkg.sv
// Shared types and defaults for the KNN distance calculator.
package knn_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_COORD_W    = 16;
  localparam int DEF_LABEL_BITS = 8;
  localparam int DEF_CNT_W      = 16;
  localparam int STAGES         = 2;

  // Wide all-ones; truncated to DATA_W where used.
  localparam logic [63:0] DIST_MAX = '1;
endpackage

// File: rtl/knn_sq.sv
// Square of one signed coordinate difference; result is always non-negative.
module knn_sq #(
  parameter int W = 17
) (
  input  logic signed [W-1:0]   d,
  output logic        [2*W-1:0] sq
);
  logic signed [2*W-1:0] d_ext;

  assign d_ext = (2*W)'(d);
  assign sq    = $unsigned(d_ext * d_ext);
endmodule

// File: rtl/knn_dist_calc.sv
// Streams training samples, emits squared distance to the latched test point.
// Build option: KNN_DIST_SAT_EN saturates overflowing distances instead of wrapping.
module knn_dist_calc
  import knn_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int LABEL_BITS = DEF_LABEL_BITS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [COORD_W-1:0]    test_x,
  input  logic [COORD_W-1:0]    test_y,
  input  logic [CNT_W-1:0]      nbr_points,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COORD_W-1:0]    data_x,
  input  logic [COORD_W-1:0]    data_y,
  input  logic [LABEL_BITS-1:0] data_label,
  output logic [DATA_W-1:0]     dist_entry,
  output logic [LABEL_BITS-1:0] label_entry,
  output logic                  en_list,
  output logic                  busy,
  output logic                  done
);
  localparam int SUM_W = 2*COORD_W + 3;

`ifdef KNN_DIST_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt, cnt_inc, nbr_lat;
  logic [COORD_W-1:0]      tx, ty;
  logic                    xfer;
  logic [STAGES:1]         vld_pipe;
  logic signed [COORD_W:0] dx, dy;
  logic [LABEL_BITS-1:0]   lbl1;
  logic [2*COORD_W+1:0]    sqx, sqy;
  logic [SUM_W-1:0]        sum;
  logic [DATA_W-1:0]       dist_red;

  assign xfer    = in_valid & in_ready;
  assign cnt_inc = cnt + CNT_W'(1);
  assign en_list = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      nbr_lat  <= '0;
      tx       <= '0;
      ty       <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          tx      <= test_x;
          ty      <= test_y;
          nbr_lat <= nbr_points;
          cnt     <= '0;
          if (nbr_points != '0) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        RUN: if (xfer) begin
          cnt <= cnt_inc;
          if (cnt_inc == nbr_lat) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: if (vld_pipe == '0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  knn_sq #(.W(COORD_W+1)) u_sq_x (.d(dx), .sq(sqx));
  knn_sq #(.W(COORD_W+1)) u_sq_y (.d(dy), .sq(sqy));

  assign sum = SUM_W'(sqx) + SUM_W'(sqy);

  generate
    if (SUM_W > DATA_W) begin : g_narrow
      logic ovf;
      assign ovf      = |sum[SUM_W-1:DATA_W];
      assign dist_red = (SAT_EN && ovf) ? DATA_W'(DIST_MAX) : sum[DATA_W-1:0];
    end else begin : g_wide
      assign dist_red = DATA_W'(sum);
    end
  endgenerate

  // Fixed 2-cycle pipe, no backpressure: en_list trails each transfer by two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      dx          <= '0;
      dy          <= '0;
      lbl1        <= '0;
      dist_entry  <= '0;
      label_entry <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
      if (xfer) begin
        dx   <= (COORD_W+1)'($signed(data_x)) - (COORD_W+1)'($signed(tx));
        dy   <= (COORD_W+1)'($signed(data_y)) - (COORD_W+1)'($signed(ty));
        lbl1 <= data_label;
      end
      if (vld_pipe[1]) begin
        dist_entry  <= dist_red;
        label_entry <= lbl1;
      end
    end
  end
endmodule

// File: tb/tb_knn_dist_calc.sv
// Directed bench with scoreboard queues for knn_dist_calc (default widths).
module tb_knn_dist_calc;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, en_list, busy, done;
  logic [15:0] test_x, test_y, data_x, data_y, nbr_points;
  logic [7:0]  data_label, label_entry;
  logic [31:0] dist_entry;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  l;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  knn_dist_calc dut (
    .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y),
    .nbr_points(nbr_points), .in_valid(in_valid), .in_ready(in_ready),
    .data_x(data_x), .data_y(data_y), .data_label(data_label),
    .dist_entry(dist_entry), .label_entry(label_entry), .en_list(en_list),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: record handshake times, check every en_list pulse against the queues.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) cyc_q.push_back(cyc + 2);
    if (en_list) begin
      if (exp_q.size() == 0 || cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_en_list actual=1 expected=0 dist=%0h", dist_entry);
      end else begin
        exp_t        e;
        int unsigned c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("en_list_cycle", 64'(cyc), 64'(c));
        chk("dist_entry", 64'(dist_entry), 64'(e.d));
        chk("label_entry", 64'(label_entry), 64'(e.l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] n);
    test_x = tx; test_y = ty; nbr_points = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [7:0] l,
                      input logic [31:0] d);
    exp_t e;
    int   k;
    data_x = x; data_y = y; data_label = l; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    e.d = d; e.l = l;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 20) begin tick(); k++; end
    chk("done", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    test_x = '0; test_y = '0; nbr_points = '0;
    data_x = '0; data_y = '0; data_label = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_dist", 64'(dist_entry), 64'd0);
    chk("rst_label", 64'(label_entry), 64'd0);

    // Three back-to-back samples around the origin.
    run_start(16'd0, 16'd0, 16'd3);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_in_ready", 64'(in_ready), 64'd1);
    send(16'd3, 16'd4, 8'd1, 32'd25);
    send(-16'sd6, 16'd8, 8'd2, 32'd100);
    send(16'd0, 16'd0, 8'd3, 32'd0);
    in_valid = 1'b0;
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    wait_done();
    chk("hold_dist", 64'(dist_entry), 64'd0);
    chk("hold_label", 64'(label_entry), 64'd3);

    // Zero-point run goes straight to DONE.
    run_start(16'd5, 16'd5, 16'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick(); tick(); tick();

    // Extreme coordinates: overflow of a 32-bit distance.
    run_start(16'h8000, 16'h8000, 16'd1);
`ifdef KNN_DIST_SAT_EN
    send(16'h7FFF, 16'h7FFF, 8'd9, 32'hFFFF_FFFF);
`else
    send(16'h7FFF, 16'h7FFF, 8'd9, 32'hFFFC_0002);
`endif
    in_valid = 1'b0;
    wait_done();
`ifdef KNN_DIST_SAT_EN
    chk("ovf_hold", 64'(dist_entry), 64'hFFFF_FFFF);
`else
    chk("ovf_hold", 64'(dist_entry), 64'hFFFC_0002);
`endif

    // Gapped in_valid, two points.
    run_start(16'd0, 16'd0, 16'd2);
    send(16'd1, 16'd0, 8'd4, 32'd1);
    in_valid = 1'b0;
    tick();
    send(16'd0, 16'd2, 8'd5, 32'd4);
    in_valid = 1'b0;
    chk("count_in_ready", 64'(in_ready), 64'd0);
    wait_done();

    // start during RUN must not disturb the test point or the count.
    run_start(16'd1, 16'd1, 16'd2);
    run_start(16'd100, 16'd100, 16'd5);
    send(16'd4, 16'd5, 8'd7, 32'd25);
    send(16'd1, 16'd1, 8'd8, 32'd0);
    in_valid = 1'b0;
    chk("restart_ignored_in_ready", 64'(in_ready), 64'd0);
    wait_done();

    // Reset one cycle after a transfer drops the in-flight sample.
    run_start(16'd0, 16'd0, 16'd3);
    data_x = 16'd5; data_y = 16'd0; data_label = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_en_list", 64'(en_list), 64'd0);
    chk("mid_rst_dist", 64'(dist_entry), 64'd0);
    chk("mid_rst_label", 64'(label_entry), 64'd0);
    repeat (5) tick();

    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    chk("leftover_timing", 64'(cyc_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
